// File: rtl/nibble_ram_reader_if.sv
// Request/response and RAM pin bundle for the nibble-serial RAM read port.
// The slave modport is the reader itself; the master is the requester plus the RAM model.
interface nibble_ram_reader_if #(
    parameter int RAM_PINS  = 4,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic                 req_valid;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 ram_start;
    logic [RAM_PINS-1:0]  ram_addr;
    logic [RAM_PINS-1:0]  ram_data;

    modport slave (
        input  req_valid, req_addr, ram_data,
        output req_ready, rsp_valid, rsp_data, ram_start, ram_addr
    );

    modport master (
        output req_valid, req_addr, ram_data,
        input  req_ready, rsp_valid, rsp_data, ram_start, ram_addr
    );
endinterface

// File: rtl/nibble_ram_reader.sv
// Nibble-serial RAM read port: shifts an address out LSB nibble first, waits LATENCY cycles, shifts a word in.
// Response strobes NA+LATENCY+ND+1 cycles after accept; one request in flight, no backpressure on rsp_valid.
module nibble_ram_reader #(
    parameter int RAM_PINS  = 4,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16,
    parameter int LATENCY   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_ram_reader_if.slave  bus
);
    localparam int NA   = ADDR_BITS / RAM_PINS;
    localparam int ND   = DATA_BITS / RAM_PINS;
    localparam int NMAX = (NA > ND) ? NA : ND;
    localparam int CW   = $clog2(NMAX) + 1;
    localparam logic [CW-1:0] NA_LAST   = CW'(NA - 1);
    localparam logic [CW-1:0] ND_LAST   = CW'(ND - 1);
    localparam logic [3:0]    WAIT_LAST = 4'(LATENCY - 1);

    if ((ADDR_BITS % RAM_PINS) != 0 || (DATA_BITS % RAM_PINS) != 0 ||
        LATENCY > 15 || LATENCY < 0) begin : g_bad_params
        $error("nibble_ram_reader: illegal RAM_PINS/ADDR_BITS/DATA_BITS/LATENCY combination");
    end

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

    state_t               state;
    logic [CW-1:0]        nib_cnt;
    logic [3:0]           wait_cnt;
    logic [ADDR_BITS-1:0] addr_sh;
    logic [DATA_BITS-1:0] data_sh;
    logic [DATA_BITS-1:0] data_next;
    logic [RAM_PINS-1:0]  ram_addr_q;
    logic                 ram_start_q;
    logic                 rsp_valid_q;
    logic [DATA_BITS-1:0] rsp_data_q;

    // Drop the incoming nibble into its slot; the completed word feeds both the
    // assembly register and rsp_data on the final data edge.
    always_comb begin
        data_next = data_sh;
        data_next[int'(nib_cnt)*RAM_PINS +: RAM_PINS] = bus.ram_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            nib_cnt     <= '0;
            wait_cnt    <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            ram_addr_q  <= '0;
            ram_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ram_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state       <= ADDR;
                        ram_addr_q  <= bus.req_addr[RAM_PINS-1:0];
                        addr_sh     <= bus.req_addr >> RAM_PINS;
                        ram_start_q <= 1'b1;
                        nib_cnt     <= '0;
                        data_sh     <= '0;
                    end
                end
                ADDR: begin
                    if (nib_cnt == NA_LAST) begin
                        ram_addr_q <= '0;
                        nib_cnt    <= '0;
                        wait_cnt   <= '0;
                        state      <= (LATENCY == 0) ? DATA : WAIT;
                    end else begin
                        ram_addr_q <= addr_sh[RAM_PINS-1:0];
                        addr_sh    <= addr_sh >> RAM_PINS;
                        nib_cnt    <= nib_cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DATA: begin
                    data_sh <= data_next;
                    if (nib_cnt == ND_LAST) begin
                        state       <= IDLE;
                        nib_cnt     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= data_next;
                    end else begin
                        nib_cnt <= nib_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.ram_start = ram_start_q;
    assign bus.ram_addr  = ram_addr_q;
endmodule

// File: tb/tb_nibble_ram_reader.sv
// Bench for nibble_ram_reader: directed table reads, corner sequences, and a randomized run against a cycle-offset model.
module tb_nibble_ram_reader;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    nibble_ram_reader_if #(.RAM_PINS(4), .ADDR_BITS(16), .DATA_BITS(16)) a_if ();
    nibble_ram_reader_if #(.RAM_PINS(4), .ADDR_BITS(16), .DATA_BITS(16)) z_if ();
    nibble_ram_reader_if #(.RAM_PINS(8), .ADDR_BITS(16), .DATA_BITS(8))  w_if ();

    nibble_ram_reader #(.RAM_PINS(4), .ADDR_BITS(16), .DATA_BITS(16), .LATENCY(2))
        u_def (.clk(clk), .rst_n(rst_n), .bus(a_if));
    nibble_ram_reader #(.RAM_PINS(4), .ADDR_BITS(16), .DATA_BITS(16), .LATENCY(0))
        u_lat0 (.clk(clk), .rst_n(rst_n), .bus(z_if));
    nibble_ram_reader #(.RAM_PINS(8), .ADDR_BITS(16), .DATA_BITS(8), .LATENCY(2))
        u_byte (.clk(clk), .rst_n(rst_n), .bus(w_if));

    localparam int NA  = 4;
    localparam int LAT = 2;
    localparam int ND  = 4;
    localparam int TOT = NA + LAT + ND;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_rsp = 16'h0;

    // nib_seq / din_seq list nibbles in pin order, first one in the top nibble.
    typedef struct {
        logic [15:0] addr;
        logic [15:0] nib_seq;
        logic [15:0] din_seq;
        logic [15:0] rsp;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_read(input vec_t v);
        logic [15:0] ns;
        logic [15:0] ds;
        ns = v.nib_seq;
        ds = v.din_seq;
        @(negedge clk);
        chk("rd_ready_idle", 64'(a_if.req_ready), 64'd1);
        a_if.req_valid = 1'b1;
        a_if.req_addr  = v.addr;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 4) chk("rd_addr", 64'(a_if.ram_addr), 64'(ns[15-4*(k-1) -: 4]));
            else        chk("rd_addr_zero", 64'(a_if.ram_addr), 64'd0);
            chk("rd_start", 64'(a_if.ram_start), 64'(k == 1));
            chk("rd_ready", 64'(a_if.req_ready), 64'(k == 11));
            chk("rd_rsp_valid", 64'(a_if.rsp_valid), 64'(k == 11));
            chk("rd_rsp_data", 64'(a_if.rsp_data), 64'((k == 11) ? v.rsp : last_rsp));
            a_if.req_valid = (k < 11) ? 1'($urandom) : 1'b0;
            a_if.req_addr  = 16'($urandom);
            a_if.ram_data  = (k >= 7 && k <= 10) ? ds[15-4*(k-7) -: 4] : 4'($urandom);
        end
        last_rsp = v.rsp;
    endtask

    initial begin
        logic [15:0] a1, a2, az, dz;
        logic [15:0] m_addr, m_word, exp_rsp;
        int t_rsp1, t_rsp2, pulses, t0, k;
        bit act;

        a_if.req_valid = 1'b0; a_if.req_addr = '0; a_if.ram_data = '0;
        z_if.req_valid = 1'b0; z_if.req_addr = '0; z_if.ram_data = '0;
        w_if.req_valid = 1'b0; w_if.req_addr = '0; w_if.ram_data = '0;

        vecs[0] = '{16'hBEEF, 16'hFEEB, 16'h1234, 16'h4321};
        vecs[1] = '{16'h1234, 16'h4321, 16'h5678, 16'h8765};
        vecs[2] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[3] = '{16'hA50F, 16'hF05A, 16'h0F0F, 16'hF0F0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h9C3E, 16'hE3C9};

        // Reset values, sampled while reset is held.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready",     64'(a_if.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(a_if.rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(a_if.rsp_data),  64'd0);
        chk("rst_start",     64'(a_if.ram_start), 64'd0);
        chk("rst_addr",      64'(a_if.ram_addr),  64'd0);
        chk("rst_ready_z",   64'(z_if.req_ready), 64'd1);
        chk("rst_ready_w",   64'(w_if.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) do_read(vecs[i]);

        // Back-to-back: req_valid stays high, second address shown on the strobe cycle.
        a1 = 16'h1234; a2 = 16'h5678;
        t_rsp1 = -1; t_rsp2 = -1;
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_addr = a1; a_if.ram_data = 4'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 4) chk("b2b_addr1", 64'(a_if.ram_addr), 64'((a1 >> (4*(c-1))) & 16'hF));
            if (t_rsp1 > 0 && c > t_rsp1 && c <= t_rsp1 + 4)
                chk("b2b_addr2", 64'(a_if.ram_addr), 64'((a2 >> (4*(c-t_rsp1-1))) & 16'hF));
            if (a_if.rsp_valid) begin
                if (t_rsp1 < 0) begin
                    t_rsp1 = c;
                    a_if.req_addr = a2;
                end else begin
                    t_rsp2 = c;
                    chk("b2b_data", 64'(a_if.rsp_data), 64'd0);
                    a_if.req_valid = 1'b0;
                    break;
                end
            end
        end
        a_if.req_valid = 1'b0;
        chk("b2b_first_rsp", 64'(t_rsp1), 64'd11);
        chk("b2b_gap",       64'(t_rsp2 - t_rsp1), 64'd11);
        last_rsp = 16'h0;

        // LATENCY=0 instance.
        az = 16'h00A5; dz = 16'h71C3;
        @(negedge clk);
        z_if.req_valid = 1'b1; z_if.req_addr = az;
        for (int kk = 1; kk <= 9; kk++) begin
            @(negedge clk);
            chk("lat0_addr",  64'(z_if.ram_addr), 64'((kk <= 4) ? ((az >> (4*(kk-1))) & 16'hF) : 16'h0));
            chk("lat0_start", 64'(z_if.ram_start), 64'(kk == 1));
            chk("lat0_valid", 64'(z_if.rsp_valid), 64'(kk == 9));
            if (kk == 9) chk("lat0_data", 64'(z_if.rsp_data), 64'h3C17);
            z_if.req_valid = 1'b0;
            z_if.ram_data  = (kk >= 5 && kk <= 8) ? dz[15-4*(kk-5) -: 4] : 4'($urandom);
        end

        // Byte-wide pins, single data beat.
        @(negedge clk);
        w_if.req_valid = 1'b1; w_if.req_addr = 16'hC3A5;
        for (int kk = 1; kk <= 6; kk++) begin
            @(negedge clk);
            chk("byte_addr",  64'(w_if.ram_addr),
                (kk == 1) ? 64'hA5 : (kk == 2) ? 64'hC3 : 64'h0);
            chk("byte_start", 64'(w_if.ram_start), 64'(kk == 1));
            chk("byte_valid", 64'(w_if.rsp_valid), 64'(kk == 6));
            if (kk == 6) chk("byte_data", 64'(w_if.rsp_data), 64'h7E);
            w_if.req_valid = 1'b0;
            w_if.ram_data  = (kk == 5) ? 8'h7E : 8'($urandom);
        end

        // Reset in the middle of the address phase.
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_addr = 16'hBEEF;
        @(negedge clk);
        a_if.req_valid = 1'b0;
        @(negedge clk);
        chk("rstaddr_pre", 64'(a_if.ram_addr), 64'hE);
        #2 rst_n = 1'b0;
        #1 chk("rstaddr_async", 64'(a_if.ram_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rsp = 16'h0;
        do_read(vecs[3]);

        // Reset after two data nibbles.
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_addr = 16'hBEEF;
        for (int kk = 1; kk <= 8; kk++) begin
            @(negedge clk);
            a_if.req_valid = 1'b0;
            a_if.ram_data  = 4'(kk + 3);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstdata_ready", 64'(a_if.req_ready), 64'd1);
        chk("rstdata_valid", 64'(a_if.rsp_valid), 64'd0);
        chk("rstdata_data",  64'(a_if.rsp_data),  64'd0);
        chk("rstdata_addr",  64'(a_if.ram_addr),  64'd0);
        chk("rstdata_start", 64'(a_if.ram_start), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (a_if.rsp_valid) pulses++;
        end
        chk("rstdata_no_rsp", 64'(pulses), 64'd0);
        last_rsp = 16'h0;
        do_read(vecs[0]);

        // Randomized traffic: the model tracks each transaction by its cycle offset from accept.
        act = 1'b0; t0 = 0; m_addr = '0; m_word = '0; exp_rsp = last_rsp;
        for (int c = 0; c < 600; c++) begin
            logic [3:0] e_addr;
            logic e_start, e_valid;
            @(negedge clk);
            k = c - t0;
            e_addr = 4'h0; e_start = 1'b0; e_valid = 1'b0;
            if (act && k >= 1 && k <= NA) begin
                e_addr  = 4'((m_addr >> (4*(k-1))) & 16'hF);
                e_start = (k == 1);
            end
            if (act && k == TOT + 1) begin
                e_valid = 1'b1;
                exp_rsp = m_word;
                act     = 1'b0;
            end
            chk("rnd_addr",  64'(a_if.ram_addr),  64'(e_addr));
            chk("rnd_start", 64'(a_if.ram_start), 64'(e_start));
            chk("rnd_valid", 64'(a_if.rsp_valid), 64'(e_valid));
            chk("rnd_data",  64'(a_if.rsp_data),  64'(exp_rsp));
            chk("rnd_ready", 64'(a_if.req_ready), 64'(!act));
            a_if.req_valid = ($urandom_range(0, 3) != 0);
            a_if.req_addr  = 16'($urandom);
            a_if.ram_data  = 4'($urandom);
            if (act && k >= NA + LAT + 1 && k <= TOT)
                m_word = m_word | (16'(a_if.ram_data) << (4*(k - NA - LAT - 1)));
            if (!act && a_if.req_valid) begin
                act    = 1'b1;
                t0     = c;
                m_addr = a_if.req_addr;
                m_word = 16'h0;
            end
        end
        a_if.req_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
